// File: rtl/mem_access_stage.sv
// MEM pipeline stage: runs load/store accesses over a req/ack handshake to a
// variable-latency data memory. While an access is in flight it stalls the
// upstream stages and presents a bubble to MEM/WB. A per-access timeout
// forces completion and sets a sticky fault flag if the memory never acks.
module mem_access_stage #(
  parameter int DATA_WIDTH     = 16,
  parameter int REGADDR_WIDTH  = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_reg_write,
  input  logic                     in_mem_read,
  input  logic                     in_mem_write,
  input  logic                     in_is_jal,
  input  logic [DATA_WIDTH-1:0]    in_alu_result,
  input  logic [DATA_WIDTH-1:0]    in_store_data,
  input  logic [DATA_WIDTH-1:0]    in_jal_link_value,
  input  logic [REGADDR_WIDTH-1:0] in_rd,
  output logic                     dmem_req,
  output logic                     dmem_we,
  output logic [DATA_WIDTH-1:0]    dmem_addr,
  output logic [DATA_WIDTH-1:0]    dmem_wdata,
  input  logic                     dmem_ack,
  input  logic [DATA_WIDTH-1:0]    dmem_rdata,
  output logic                     stall,
  output logic                     mem_reg_write,
  output logic                     mem_mem_read,
  output logic                     mem_is_jal,
  output logic [DATA_WIDTH-1:0]    mem_read_data,
  output logic [DATA_WIDTH-1:0]    mem_alu_result,
  output logic [DATA_WIDTH-1:0]    mem_jal_link_value,
  output logic [REGADDR_WIDTH-1:0] mem_rd,
  output logic                     mem_fault
);

  // Counter only needs to reach TIMEOUT_CYCLES-1; BUSY is left on that value.
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                   state_q, state_d;
  logic [CW-1:0]            cnt_q;
  logic                     stall_c;
  logic                     access, timeout;

  // Fields latched from EX/MEM when the access starts
  logic                     l_reg_write, l_mem_read, l_is_jal;
  logic [DATA_WIDTH-1:0]    l_alu_result, l_jal_link_value, l_rdata;
  logic [REGADDR_WIDTH-1:0] l_rd;

  assign access  = in_mem_read | in_mem_write;
  assign timeout = (cnt_q == CNT_LAST);

  // Stall drops as soon as reset asserts, even with an access still at the inputs.
  assign stall = stall_c & reset;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state plus MEM/WB-facing outputs; defaults form a bubble
  always_comb begin
    state_d            = state_q;
    stall_c            = 1'b0;
    mem_reg_write      = 1'b0;
    mem_mem_read       = 1'b0;
    mem_is_jal         = 1'b0;
    mem_read_data      = '0;
    mem_alu_result     = '0;
    mem_jal_link_value = '0;
    mem_rd             = '0;
    case (state_q)
      IDLE: begin
        if (access) begin
          stall_c = 1'b1;
          state_d = BUSY;
        end else begin
          mem_reg_write      = in_reg_write;
          mem_mem_read       = in_mem_read;
          mem_is_jal         = in_is_jal;
          mem_alu_result     = in_alu_result;
          mem_jal_link_value = in_jal_link_value;
          mem_rd             = in_rd;
        end
      end
      BUSY: begin
        stall_c = 1'b1;
        if (dmem_ack || timeout) state_d = DONE;
      end
      DONE: begin
        mem_reg_write      = l_reg_write;
        mem_mem_read       = l_mem_read;
        mem_is_jal         = l_is_jal;
        mem_read_data      = l_rdata;
        mem_alu_result     = l_alu_result;
        mem_jal_link_value = l_jal_link_value;
        mem_rd             = l_rd;
        state_d            = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Access launch, memory handshake, data capture, timeout and sticky fault
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dmem_req         <= 1'b0;
      dmem_we          <= 1'b0;
      dmem_addr        <= '0;
      dmem_wdata       <= '0;
      mem_fault        <= 1'b0;
      cnt_q            <= '0;
      l_reg_write      <= 1'b0;
      l_mem_read       <= 1'b0;
      l_is_jal         <= 1'b0;
      l_alu_result     <= '0;
      l_jal_link_value <= '0;
      l_rd             <= '0;
      l_rdata          <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (access) begin
            l_reg_write      <= in_reg_write;
            // A read+write combination is treated as a store
            l_mem_read       <= in_mem_read & ~in_mem_write;
            l_is_jal         <= in_is_jal;
            l_alu_result     <= in_alu_result;
            l_jal_link_value <= in_jal_link_value;
            l_rd             <= in_rd;
            dmem_req         <= 1'b1;
            dmem_we          <= in_mem_write;
            dmem_addr        <= in_alu_result;
            dmem_wdata       <= in_store_data;
            cnt_q            <= '0;
          end
        end
        BUSY: begin
          cnt_q <= cnt_q + CW'(1);
          // Ack takes priority over a coincident timeout
          if (dmem_ack) begin
            l_rdata  <= l_mem_read ? dmem_rdata : '0;
            dmem_req <= 1'b0;
          end else if (timeout) begin
            l_rdata   <= '0;
            mem_fault <= 1'b1;
            dmem_req  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Transaction-level bench for mem_access_stage: each instruction is driven,
// the memory responds after a chosen delay, and the stall length, bus values
// and writeback fields are checked against expectations built from the rules.
module tb_mem_access_stage;
  localparam int DW = 16;
  localparam int RW = 4;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_reg_write, in_mem_read, in_mem_write, in_is_jal;
  logic [DW-1:0] in_alu_result, in_store_data, in_jal_link_value;
  logic [RW-1:0] in_rd;
  logic          dmem_req, dmem_we, dmem_ack;
  logic [DW-1:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic          stall, mem_reg_write, mem_mem_read, mem_is_jal, mem_fault;
  logic [DW-1:0] mem_read_data, mem_alu_result, mem_jal_link_value;
  logic [RW-1:0] mem_rd;

  int passed = 0;
  int total  = 0;
  bit fault_m = 1'b0;  // model of the sticky fault flag

  always #5 clk = ~clk;

  mem_access_stage #(.DATA_WIDTH(DW), .REGADDR_WIDTH(RW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .in_reg_write(in_reg_write), .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
    .in_is_jal(in_is_jal), .in_alu_result(in_alu_result), .in_store_data(in_store_data),
    .in_jal_link_value(in_jal_link_value), .in_rd(in_rd),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .stall(stall),
    .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read), .mem_is_jal(mem_is_jal),
    .mem_read_data(mem_read_data), .mem_alu_result(mem_alu_result),
    .mem_jal_link_value(mem_jal_link_value), .mem_rd(mem_rd), .mem_fault(mem_fault)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // One instruction through the stage. delay = BUSY cycle carrying the ack;
  // any delay above TO means the memory never acks.
  task automatic run_instr(input bit rw, input bit mr, input bit mw, input bit jal,
                           input logic [DW-1:0] alu, input logic [DW-1:0] sd,
                           input logic [DW-1:0] link, input logic [RW-1:0] rd,
                           input int delay, input logic [DW-1:0] ack_data);
    bit acked;
    int busy_n;
    logic [DW-1:0] exp_rd;
    @(negedge clk);
    in_reg_write = rw; in_mem_read = mr; in_mem_write = mw; in_is_jal = jal;
    in_alu_result = alu; in_store_data = sd; in_jal_link_value = link; in_rd = rd;
    dmem_ack = 1'($urandom);          // ack seen in IDLE must be ignored
    dmem_rdata = DW'($urandom);
    #1;
    if (!(mr | mw)) begin
      chk("pass_stall", stall, 0);
      chk("pass_req", dmem_req, 0);
      chk("pass_regw", mem_reg_write, rw);
      chk("pass_jal", mem_is_jal, jal);
      chk("pass_alu", mem_alu_result, alu);
      chk("pass_link", mem_jal_link_value, link);
      chk("pass_rd", mem_rd, rd);
      chk("pass_rdata", mem_read_data, 0);
      chk("pass_fault", mem_fault, fault_m);
      return;
    end
    chk("idle_stall", stall, 1);
    chk("idle_bubble", {mem_reg_write, mem_mem_read, mem_is_jal}, 0);
    acked  = (delay <= TO);
    busy_n = acked ? delay : TO;
    for (int i = 1; i <= busy_n; i++) begin
      @(negedge clk);
      dmem_ack   = acked && (i == delay);
      dmem_rdata = dmem_ack ? ack_data : DW'($urandom);
      #1;
      chk("busy_stall", stall, 1);
      chk("busy_req", dmem_req, 1);
      chk("busy_we", dmem_we, mw);
      chk("busy_addr", dmem_addr, alu);
      chk("busy_wdata", dmem_wdata, sd);
      chk("busy_bubble", {mem_reg_write, mem_mem_read, mem_is_jal, mem_alu_result}, 0);
    end
    if (!acked) fault_m = 1'b1;
    exp_rd = (acked && mr && !mw) ? ack_data : '0;
    @(negedge clk);
    dmem_ack = 1'($urandom);          // ack seen in DONE must be ignored
    dmem_rdata = DW'($urandom);
    #1;
    chk("done_stall", stall, 0);
    chk("done_req", dmem_req, 0);
    chk("done_regw", mem_reg_write, rw);
    chk("done_mrd", mem_mem_read, mr & ~mw);
    chk("done_jal", mem_is_jal, jal);
    chk("done_rdata", mem_read_data, exp_rd);
    chk("done_alu", mem_alu_result, alu);
    chk("done_link", mem_jal_link_value, link);
    chk("done_rd", mem_rd, rd);
    chk("done_fault", mem_fault, fault_m);
  endtask

  initial begin
    reset = 1'b0;
    {in_reg_write, in_mem_read, in_mem_write, in_is_jal} = '0;
    in_alu_result = '0; in_store_data = '0; in_jal_link_value = '0; in_rd = '0;
    dmem_ack = 1'b0; dmem_rdata = '0;
    #12;
    chk("rst_req", dmem_req, 0);
    chk("rst_stall", stall, 0);
    chk("rst_fault", mem_fault, 0);
    chk("rst_addr", dmem_addr, 0);
    @(negedge clk); reset = 1'b1;

    // Directed cases
    run_instr(1, 0, 0, 0, 16'h1234, 16'h0, 16'h0, 4'd3, 0, 16'h0);        // ALU op
    run_instr(1, 1, 0, 0, 16'h0040, 16'h0, 16'h0, 4'd5, 1, 16'hBEEF);     // load, ack k=1
    run_instr(0, 0, 1, 0, 16'h0010, 16'h00AA, 16'h0, 4'd0, 4, 16'h5555);  // store, ack k=4
    run_instr(1, 1, 1, 0, 16'h0020, 16'h0077, 16'h0, 4'd6, 2, 16'h9999);  // read+write = store
    run_instr(1, 1, 0, 0, 16'h0042, 16'h0, 16'h0, 4'd7, 2, 16'h1111);     // back-to-back loads
    run_instr(1, 1, 0, 0, 16'h0044, 16'h0, 16'h0, 4'd8, 2, 16'h2222);
    run_instr(1, 1, 0, 0, 16'h0050, 16'h0, 16'h0, 4'd9, TO, 16'h3333);    // ack on last BUSY cycle
    chk("ack_beats_timeout", mem_fault, 0);
    run_instr(1, 1, 0, 0, 16'h0060, 16'h0, 16'h0, 4'd2, 99, 16'h0);       // timeout
    run_instr(1, 0, 0, 1, 16'h0ABC, 16'h0, 16'h0102, 4'd1, 0, 16'h0);     // JAL after fault

    // Random mix
    for (int n = 0; n < 60; n++) begin
      int kind;
      bit rw, mr, mw, jal;
      kind = $urandom_range(0, 4);
      rw = 1'($urandom); jal = 1'b0; mr = 1'b0; mw = 1'b0;
      case (kind)
        1: mr = 1'b1;
        2: mw = 1'b1;
        3: begin mr = 1'b1; mw = 1'b1; end
        4: jal = 1'b1;
        default: ;
      endcase
      run_instr(rw, mr, mw, jal, DW'($urandom), DW'($urandom), DW'($urandom), RW'($urandom),
                $urandom_range(1, TO + 4), DW'($urandom));
    end

    // Reset in the middle of an access
    @(negedge clk);
    in_reg_write = 1'b1; in_mem_read = 1'b1; in_mem_write = 1'b0; in_is_jal = 1'b0;
    in_alu_result = 16'h0070; in_rd = 4'd4; dmem_ack = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("mid_req", dmem_req, 1);
    reset = 1'b0;
    #1;
    chk("async_req", dmem_req, 0);
    chk("async_stall", stall, 0);
    chk("async_fault", mem_fault, 0);
    fault_m = 1'b0;
    {in_reg_write, in_mem_read, in_mem_write} = '0;
    @(negedge clk); reset = 1'b1;
    run_instr(1, 0, 0, 0, 16'h4321, 16'h0, 16'h0, 4'd11, 0, 16'h0);       // back in IDLE
    run_instr(1, 1, 0, 0, 16'h0080, 16'h0, 16'h0, 4'd12, 3, 16'hCAFE);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Safety net so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got timeout, expected completion");
    $fatal(1);
  end
endmodule
